onchip_mem_stream_reader: RTL

Avalon-MM read master that sits directly upstream of the 1024×32 single-port on-chip memory's s1 slave. It drains a programmed word range into an Avalon-ST source with ready/valid backpressure. A small credit-controlled FIFO absorbs the memory's fixed one-cycle read latency, so stalls on the stream side never lose data. It is used to stream buffered samples out of on-chip RAM to downstream processing.

---
 rtl/onchip_mem_stream_reader_if.sv | 35 +++
 rtl/onchip_mem_stream_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/onchip_mem_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_stream_reader_if
// Purpose  : Avalon-MM read port and Avalon-ST source bundle for the reader.
// Revision : 1.0
// ============================================================================
interface onchip_mem_stream_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_chipselect;
    logic                  mem_write;
    logic [3:0]            mem_byteenable;
    logic                  mem_clken;
    logic [DATA_WIDTH-1:0] mem_readdata;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  st_valid;
    logic                  st_ready;
    logic                  st_startofpacket;
    logic                  st_endofpacket;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output st_data, st_valid, st_startofpacket, st_endofpacket,
        input  mem_readdata, st_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  st_data, st_valid, st_startofpacket, st_endofpacket,
        output mem_readdata, st_ready
    );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_stream_reader
// Purpose  : Streams a word range of on-chip RAM out as one Avalon-ST packet.
// Revision : 1.0
// ============================================================================
module onchip_mem_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    onchip_mem_stream_reader_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] c_max_len = LW'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_issued;
    logic [LW-1:0]         r_beats;
    logic                  r_inflight;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [LW-1:0]         w_len_clamped;
    logic                  w_credit;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_eop;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_finish;

    assign w_len_clamped = (length > c_max_len) ? c_max_len : length;
    // A read may only go out if its data is guaranteed a FIFO slot next cycle.
    assign w_credit      = (r_count + CW'(r_inflight)) < CW'(FIFO_DEPTH);
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && bus.st_ready;
    assign w_eop         = (r_beats == r_len - LW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_len_clamped != '0) begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                if ((r_issued != r_len) && w_credit) begin
                    w_issue = 1'b1;
                    if (r_issued + LW'(1) == r_len) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_pop && w_eop) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_beats    <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_done     <= (w_accept && (w_len_clamped == '0)) || w_finish;
            r_inflight <= w_issue;
            if (w_pop) begin
                r_beats  <= r_beats + LW'(1);
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_accept) begin
                r_addr   <= base_addr;
                r_len    <= w_len_clamped;
                r_issued <= '0;
                r_beats  <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_issued <= r_issued + LW'(1);
            end
            // Memory data lands exactly one cycle after the strobe; credit ensures room.
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= bus.mem_readdata;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            r_count <= r_count + CW'(r_inflight) - CW'(w_pop);
        end
    end

    assign busy                 = (r_state != IDLE);
    assign done                 = r_done;
    assign bus.mem_address      = r_addr;
    assign bus.mem_chipselect   = w_issue;
    assign bus.mem_write        = 1'b0;
    assign bus.mem_byteenable   = 4'hF;
    assign bus.mem_clken        = 1'b1;
    assign bus.st_data          = r_fifo[r_rd_ptr];
    assign bus.st_valid         = w_valid;
    assign bus.st_startofpacket = w_valid && (r_beats == '0);
    assign bus.st_endofpacket   = w_valid && w_eop;
endmodule
`default_nettype wire
